// File: rtl/mod12_count_checker_if.sv
// Observation bundle between a MOD12 up/down counter harness and its checker.
// Signal protocol: there is no valid/ready pair. Every posedge of the shared
// clock is one observation. The master side drives the sampled counter
// controls and count, and the slave (checker) side returns its results.
interface mod12_count_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 16
) ();
    // Observed counter controls and output
    logic                 dut_reset;
    logic                 mode;
    logic                 load;
    logic [WIDTH-1:0]     data_in;
    logic [WIDTH-1:0]     count;
    logic                 check_en;

    // Checker results
    logic [1:0]           state;
    logic [WIDTH-1:0]     exp_count;
    logic                 mismatch;
    logic                 illegal_ld;
    logic [ERR_CNT_W-1:0] err_count;
    logic [ERR_CNT_W-1:0] wrap_count;

    modport master (
        output dut_reset, mode, load, data_in, count, check_en,
        input  state, exp_count, mismatch, illegal_ld, err_count, wrap_count
    );

    modport slave (
        input  dut_reset, mode, load, data_in, count, check_en,
        output state, exp_count, mismatch, illegal_ld, err_count, wrap_count
    );
endinterface

// File: rtl/mod12_count_checker.sv
// Passive checker for a MOD12 up/down counter. Tracks the counter with a
// cycle-accurate model, delays the expectation by DUT_LATENCY edges, and
// compares it to the observed count. Keeps saturating error/wrap statistics.
module mod12_count_checker #(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 12,
    parameter int DUT_LATENCY = 1,
    parameter int ERR_CNT_W   = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    mod12_count_checker_if.slave io_bus
);
    typedef enum logic [1:0] {
        ST_UNSYNC = 2'b00,
        ST_CHECK  = 2'b01,
        ST_HALT   = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0]     LP_MOD_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]       LP_MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [ERR_CNT_W-1:0] LP_SAT     = '1;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_exp;
    // Stage 0 is the newest expectation, stage DUT_LATENCY-1 is compared.
    logic [WIDTH-1:0]       r_dl_val [DUT_LATENCY];
    logic [DUT_LATENCY-1:0] r_dl_vld;
    logic                   r_mismatch;
    logic                   r_illegal_ld;
    logic [ERR_CNT_W-1:0]   r_err_count;
    logic [ERR_CNT_W-1:0]   r_wrap_count;

    state_t                 w_next_state;
    logic [WIDTH-1:0]       w_exp_next;
    logic                   w_wrap;
    logic                   w_illegal;
    logic                   w_legal_data;
    logic                   w_cmp_en;
    logic                   w_miss;

    // Model next value, wrap/illegal detection, compare and next FSM state.
    always_comb begin
        w_legal_data = ({1'b0, io_bus.data_in} < LP_MOD_EXT);
        w_cmp_en     = r_dl_vld[DUT_LATENCY-1] && io_bus.check_en && (r_state != ST_HALT);
        w_miss       = w_cmp_en && (r_dl_val[DUT_LATENCY-1] != io_bus.count);
        w_exp_next   = r_exp;
        w_wrap       = 1'b0;
        w_illegal    = 1'b0;
        w_next_state = r_state;
        if (r_state != ST_HALT) begin
            // Counter priority: dut_reset > load > mode.
            if (io_bus.dut_reset) begin
                w_exp_next = '0;
            end else if (io_bus.load) begin
                w_exp_next = io_bus.data_in;
                w_illegal  = !w_legal_data;
            end else if (io_bus.mode) begin
                if (r_exp == LP_MOD_MAX) begin
                    w_exp_next = '0;
                    w_wrap     = 1'b1;
                end else begin
                    w_exp_next = r_exp + 1'b1;
                end
            end else begin
                if (r_exp == '0) begin
                    w_exp_next = LP_MOD_MAX;
                    w_wrap     = 1'b1;
                end else begin
                    w_exp_next = r_exp - 1'b1;
                end
            end

            case (r_state)
                ST_UNSYNC: begin
                    if (io_bus.dut_reset || (io_bus.load && w_legal_data)) begin
                        w_next_state = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // A stop-on-error halt outranks losing sync on the same edge.
                    if (STOP_ON_ERR && w_miss) begin
                        w_next_state = ST_HALT;
                    end else if (w_illegal) begin
                        w_next_state = ST_UNSYNC;
                    end
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    // FSM, model register, expectation delay line and registered result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_UNSYNC;
            r_exp        <= '0;
            r_dl_vld     <= '0;
            for (int k = 0; k < DUT_LATENCY; k++) begin
                r_dl_val[k] <= '0;
            end
            r_mismatch   <= 1'b0;
            r_illegal_ld <= 1'b0;
            r_err_count  <= '0;
            r_wrap_count <= '0;
        end else begin
            r_state      <= w_next_state;
            r_exp        <= w_exp_next;
            r_dl_val[0]  <= w_exp_next;
            r_dl_vld[0]  <= (w_next_state == ST_CHECK);
            for (int k = 1; k < DUT_LATENCY; k++) begin
                r_dl_val[k] <= r_dl_val[k-1];
                r_dl_vld[k] <= r_dl_vld[k-1];
            end
            r_mismatch   <= w_miss;
            r_illegal_ld <= w_illegal;
            if (w_miss && (r_err_count != LP_SAT)) begin
                r_err_count <= r_err_count + 1'b1;
            end
            if (w_wrap && (r_wrap_count != LP_SAT)) begin
                r_wrap_count <= r_wrap_count + 1'b1;
            end
        end
    end

    assign io_bus.state      = r_state;
    assign io_bus.exp_count  = r_exp;
    assign io_bus.mismatch   = r_mismatch;
    assign io_bus.illegal_ld = r_illegal_ld;
    assign io_bus.err_count  = r_err_count;
    assign io_bus.wrap_count = r_wrap_count;
endmodule

// File: tb/tb_mod12_count_checker.sv
// Bench for mod12_count_checker: two checker instances (latency 1 with narrow
// saturating counters, latency 3 with stop-on-error) watch a behavioural
// MOD12 counter whose output can be corrupted on chosen cycles.
module tb_mod12_count_checker;
    localparam int MOD = 12;
    localparam int L0  = 1;
    localparam int L1  = 3;
    localparam int E0  = 3;
    localparam int E1  = 16;
    localparam int HN  = 4096;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mod12_count_checker_if #(.WIDTH(4), .ERR_CNT_W(E0)) if0 ();
    mod12_count_checker_if #(.WIDTH(4), .ERR_CNT_W(E1)) if1 ();

    mod12_count_checker #(.WIDTH(4), .MODULUS(MOD), .DUT_LATENCY(L0),
                          .ERR_CNT_W(E0), .STOP_ON_ERR(1'b0)) u0 (
        .clock (clock),
        .reset (reset),
        .io_bus(if0)
    );

    mod12_count_checker #(.WIDTH(4), .MODULUS(MOD), .DUT_LATENCY(L1),
                          .ERR_CNT_W(E1), .STOP_ON_ERR(1'b1)) u1 (
        .clock (clock),
        .reset (reset),
        .io_bus(if1)
    );

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [79:0] exp_q[$];
    bit          run_active = 1'b0;
    int          edge_n = 0;

    // Counter value after each edge (the observed counter never sees the checker reset).
    int ctr_hist[HN];

    // Reference model per instance: current results plus per-edge history of
    // the expectation and whether it was taken while in sync.
    int m_state[2];
    int m_exp[2];
    int m_err[2];
    int m_wrap[2];
    int m_last_rst[2];
    bit m_mm[2];
    bit m_il[2];
    int h_exp[2][HN];
    bit h_vld[2][HN];

    function automatic logic [39:0] pk(input int st, input int e, input int mm,
                                       input int il, input int er, input int wr);
        logic [1:0]  s2;
        logic [3:0]  e4;
        logic [15:0] er16;
        logic [15:0] wr16;
        s2 = st[1:0];
        e4 = e[3:0];
        er16 = er[15:0];
        wr16 = wr[15:0];
        return {s2, e4, mm[0], il[0], er16, wr16};
    endfunction

    // One edge of the reference model for instance u (state 0 unsync, 1 check, 2 halt).
    task automatic model_edge(input int u, input int lat, input bit stop, input int emax,
                              input bit rst, input bit dr, input bit md, input bit ld,
                              input int d, input bit ce, input int cnt, input int n);
        int  e;
        int  nxt;
        int  src;
        bit  legal;
        if (rst) begin
            m_state[u] = 0; m_exp[u] = 0; m_err[u] = 0; m_wrap[u] = 0;
            m_mm[u] = 1'b0; m_il[u] = 1'b0;
            m_last_rst[u] = n;
            h_exp[u][n] = 0; h_vld[u][n] = 1'b0;
            return;
        end
        legal = (d < MOD);
        src = n - lat;
        m_mm[u] = 1'b0;
        if (src >= 0 && src > m_last_rst[u] && ce && m_state[u] != 2) begin
            if (h_vld[u][src] && h_exp[u][src] != cnt) m_mm[u] = 1'b1;
        end
        m_il[u] = 1'b0;
        if (m_state[u] == 2) begin
            h_exp[u][n] = m_exp[u];
            h_vld[u][n] = 1'b0;
        end else begin
            e = m_exp[u];
            if (dr) e = 0;
            else if (ld) begin
                e = d;
                m_il[u] = !legal;
            end else if (md) begin
                if (e == MOD - 1) begin
                    e = 0;
                    if (m_wrap[u] < emax) m_wrap[u]++;
                end else e = (e + 1) % 16;
            end else begin
                if (e == 0) begin
                    e = MOD - 1;
                    if (m_wrap[u] < emax) m_wrap[u]++;
                end else e = e - 1;
            end
            nxt = m_state[u];
            if (m_state[u] == 0 && (dr || (ld && legal))) nxt = 1;
            if (m_state[u] == 1) begin
                if (stop && m_mm[u]) nxt = 2;
                else if (m_il[u]) nxt = 0;
            end
            m_exp[u] = e;
            m_state[u] = nxt;
            h_exp[u][n] = e;
            h_vld[u][n] = (nxt == 1);
        end
        if (m_mm[u] && m_err[u] < emax) m_err[u]++;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit rst, input bit dr, input bit md, input bit ld,
                         input int d, input bit ce, input int inj);
        int c0;
        int c1;
        int prev;
        int nc;
        @(negedge clock);
        c0 = (edge_n - L0 >= 0) ? ctr_hist[edge_n - L0] : 0;
        c1 = (edge_n - L1 >= 0) ? ctr_hist[edge_n - L1] : 0;
        c0 = (c0 ^ inj) & 15;
        c1 = (c1 ^ inj) & 15;
        reset = rst;
        if0.dut_reset = dr; if0.mode = md; if0.load = ld;
        if0.data_in = d[3:0]; if0.check_en = ce; if0.count = c0[3:0];
        if1.dut_reset = dr; if1.mode = md; if1.load = ld;
        if1.data_in = d[3:0]; if1.check_en = ce; if1.count = c1[3:0];
        prev = (edge_n > 0) ? ctr_hist[edge_n - 1] : 0;
        if (dr) nc = 0;
        else if (ld) nc = d;
        else if (md) nc = (prev == MOD - 1) ? 0 : (prev + 1) % 16;
        else nc = (prev == 0) ? MOD - 1 : prev - 1;
        ctr_hist[edge_n] = nc;
        model_edge(0, L0, 1'b0, (1 << E0) - 1, rst, dr, md, ld, d, ce, c0, edge_n);
        model_edge(1, L1, 1'b1, (1 << E1) - 1, rst, dr, md, ld, d, ce, c1, edge_n);
        exp_q.push_back({pk(m_state[0], m_exp[0], int'(m_mm[0]), int'(m_il[0]), m_err[0], m_wrap[0]),
                         pk(m_state[1], m_exp[1], int'(m_mm[1]), int'(m_il[1]), m_err[1], m_wrap[1])});
        run_active = 1'b1;
        edge_n++;
    endtask

    task automatic up(input int n, input bit ce, input int inj);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 0, ce, inj);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clock) begin
        logic [79:0] ev;
        logic [39:0] a0;
        logic [39:0] a1;
        #1;
        if (run_active) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL queue_empty at time %0t: output seen with no expectation", $time);
            end else begin
                ev = exp_q.pop_front();
                a0 = pk(int'(if0.state), int'(if0.exp_count), int'(if0.mismatch),
                        int'(if0.illegal_ld), int'(if0.err_count), int'(if0.wrap_count));
                a1 = pk(int'(if1.state), int'(if1.exp_count), int'(if1.mismatch),
                        int'(if1.illegal_ld), int'(if1.err_count), int'(if1.wrap_count));
                checks++;
                if (a0 !== ev[79:40]) begin
                    failures++;
                    $display("FAIL u0_outputs t=%0t got st=%0d exp=%0d mm=%0b il=%0b err=%0d wrap=%0d want st=%0d exp=%0d mm=%0b il=%0b err=%0d wrap=%0d",
                             $time, a0[39:38], a0[37:34], a0[33], a0[32], a0[31:16], a0[15:0],
                             ev[79:78], ev[77:74], ev[73], ev[72], ev[71:56], ev[55:40]);
                end
                checks++;
                if (a1 !== ev[39:0]) begin
                    failures++;
                    $display("FAIL u1_outputs t=%0t got st=%0d exp=%0d mm=%0b il=%0b err=%0d wrap=%0d want st=%0d exp=%0d mm=%0b il=%0b err=%0d wrap=%0d",
                             $time, a1[39:38], a1[37:34], a1[33], a1[32], a1[31:16], a1[15:0],
                             ev[39:38], ev[37:34], ev[33], ev[32], ev[31:16], ev[15:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit rst;
        bit dr;
        bit md;
        bit ld;
        bit ce;
        int d;
        int inj;
        m_last_rst[0] = -1;
        m_last_rst[1] = -1;

        // Reset
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0);
        // Sync by dut_reset, count up through a wrap
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 0);
        up(14, 1'b1, 0);
        // Load 3, count down through a wrap
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0);
        // Sync at 0, count up, single corrupted sample
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 0);
        up(3, 1'b1, 0);
        up(1, 1'b1, 1);
        up(4, 1'b1, 0);
        // Illegal load drops sync; garbage count; legal load resyncs
        drive(1'b0, 1'b0, 1'b1, 1'b1, 13, 1'b1, 0);
        for (int i = 0; i < 3; i++) up(1, 1'b1, $urandom_range(1, 15));
        drive(1'b0, 1'b0, 1'b1, 1'b1, 7, 1'b1, 0);
        up(6, 1'b1, 0);
        // Reset, resync, two corrupted samples
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 0);
        up(4, 1'b1, 0);
        up(1, 1'b1, 2);
        up(2, 1'b1, 0);
        up(1, 1'b1, 3);
        up(4, 1'b1, 0);
        // Reset, dut_reset together with load 9, then compares disabled
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 9, 1'b1, 0);
        up(5, 1'b1, 0);
        for (int i = 0; i < 10; i++) up(1, 1'b0, $urandom_range(1, 15));
        up(5, 1'b1, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            dr  = ($urandom_range(0, 19) == 0);
            ld  = ($urandom_range(0, 7) == 0);
            d   = $urandom_range(0, 15);
            md  = $urandom_range(0, 1) == 1;
            ce  = ($urandom_range(0, 9) != 0);
            inj = ($urandom_range(0, 29) == 0) ? $urandom_range(1, 15) : 0;
            drive(rst, dr, md, ld, d, ce, inj);
        end

        @(posedge clock);
        #3;
        run_active = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
